// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: Set-2 scan-code parser sitting behind the PS2 receiver FIFO.
// Pops raw bytes (rdy/data/done) and folds E0/F0 prefixes into single key
// events. It swallows the E1 pause sequence, tracks modifier state, and
// presents one event at a time on a valid/ready port.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   rdy       receiver FIFO non-empty
//   data      byte at receiver FIFO head
//   done      pop strobe to receiver (rdy & ~ev_valid)
//   ev_valid  event pending
//   ev_ready  consumer accepts event
//   ev_code   scan code without prefixes
//   ev_ext    event was E0-prefixed
//   ev_break  1 = release, 0 = press
//   mods      {caps_lock, alt, ctrl, shift}
//
// Optional feature: define REPEAT_FILTER_EN to suppress typematic repeats of the
// most recent make code.
module ps2_scan_decoder #(
  parameter int unsigned PAUSE_LEN = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic [7:0] data,
  output logic       done,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [3:0] mods
);

  localparam int unsigned CW = $clog2(PAUSE_LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_PAUSE} state_t;

  state_t          state, nstate;
  logic [CW-1:0]   cnt, cnt_n;
  logic            shift_l, shift_r, ctrl_l, ctrl_r, alt_l, alt_r;
  logic            caps_lock, caps_held;
  logic            accept, emit, fire;
  logic [7:0]      e_code;
  logic            e_ext, e_brk;

  assign done   = rdy & ~ev_valid;
  assign accept = rdy & done;
  assign mods   = {caps_lock, alt_l | alt_r, ctrl_l | ctrl_r, shift_l | shift_r};

  // Byte decode for the byte currently at the FIFO head.
  always_comb begin
    nstate = state;
    cnt_n  = cnt;
    emit   = 1'b0;
    e_code = data;
    e_ext  = 1'b0;
    e_brk  = 1'b0;
    unique case (state)
      S_IDLE: begin
        unique case (data)
          8'hE0: nstate = S_EXT;
          8'hF0: nstate = S_BRK;
          8'hE1: begin
            nstate = S_PAUSE;
            cnt_n  = CW'(PAUSE_LEN);
          end
          8'hAA, 8'hFA, 8'hFC, 8'h00, 8'hFF: nstate = S_IDLE;
          default: emit = 1'b1;
        endcase
      end
      S_EXT: begin
        if (data == 8'hF0) begin
          nstate = S_EXTBRK;
        end else if (data == 8'hE0) begin
          nstate = S_EXT;
        end else begin
          nstate = S_IDLE;
          // E0 12 / E0 59 are fake shifts generated around extended keys.
          emit   = (data != 8'h12) && (data != 8'h59);
          e_ext  = 1'b1;
        end
      end
      S_BRK: begin
        nstate = S_IDLE;
        emit   = 1'b1;
        e_brk  = 1'b1;
      end
      S_EXTBRK: begin
        nstate = S_IDLE;
        emit   = (data != 8'h12) && (data != 8'h59);
        e_ext  = 1'b1;
        e_brk  = 1'b1;
      end
      S_PAUSE: begin
        if (cnt == CW'(1)) begin
          nstate = S_IDLE;
          cnt_n  = '0;
          emit   = 1'b1;
          e_code = 8'hE1;
        end else begin
          cnt_n  = cnt - CW'(1);
        end
      end
      default: nstate = S_IDLE;
    endcase
  end

`ifdef REPEAT_FILTER_EN
  logic       lm_valid;
  logic [8:0] last_make;
  logic       rep_hit;

  assign rep_hit = ~e_brk & lm_valid & (last_make == {e_ext, e_code});
  assign fire    = emit & ~rep_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lm_valid  <= 1'b0;
      last_make <= '0;
    end else if (accept && emit) begin
      if (!e_brk) begin
        if (!rep_hit) begin
          lm_valid  <= 1'b1;
          last_make <= {e_ext, e_code};
        end
      end else if (lm_valid && (last_make == {e_ext, e_code})) begin
        lm_valid <= 1'b0;
      end
    end
  end
`else
  assign fire = emit;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ev_valid  <= 1'b0;
      ev_code   <= '0;
      ev_ext    <= 1'b0;
      ev_break  <= 1'b0;
      shift_l   <= 1'b0;
      shift_r   <= 1'b0;
      ctrl_l    <= 1'b0;
      ctrl_r    <= 1'b0;
      alt_l     <= 1'b0;
      alt_r     <= 1'b0;
      caps_lock <= 1'b0;
      caps_held <= 1'b0;
    end else if (accept) begin
      state <= nstate;
      cnt   <= cnt_n;
      if (fire) begin
        ev_valid <= 1'b1;
        ev_code  <= e_code;
        ev_ext   <= e_ext;
        ev_break <= e_brk;
      end
      // Modifiers follow every decoded key, including filtered repeats.
      if (emit) begin
        unique case (e_code)
          8'h12: if (!e_ext) shift_l <= ~e_brk;
          8'h59: if (!e_ext) shift_r <= ~e_brk;
          8'h14: if (e_ext) ctrl_r <= ~e_brk; else ctrl_l <= ~e_brk;
          8'h11: if (e_ext) alt_r <= ~e_brk; else alt_l <= ~e_brk;
          8'h58: begin
            if (e_brk) begin
              caps_held <= 1'b0;
            end else if (!caps_held) begin
              caps_lock <= ~caps_lock;
              caps_held <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end else if (ev_valid && ev_ready) begin
      ev_valid <= 1'b0;
    end
  end

endmodule
